// File: rtl/key_repeat_pkg.sv
// Shared types and helpers for the up/down button conditioner.
package key_repeat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_HOLD,
        ST_REPEAT,
        ST_LOCK
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Bits needed to hold the values 0 .. count-1 (ceiling log2, never below 1).
    function automatic int count_width(input int count);
        int width;
        width = 1;
        while ((longint'(1) << width) < longint'(count)) width++;
        return width;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a stable-count filter for one raw button.
module key_debounce
    import key_repeat_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic RAW,
    output logic LEVEL
);

    localparam int CW = count_width(DEB_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] diff_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= RAW;
            sync_out  <= sync_meta;
        end
    end

    // Count consecutive samples that disagree with LEVEL; any agreeing sample restarts it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            diff_cnt <= '0;
            LEVEL    <= 1'b0;
        end else if (sync_out == LEVEL) begin
            diff_cnt <= '0;
        end else if (diff_cnt == STABLE_LAST) begin
            diff_cnt <= '0;
            LEVEL    <= sync_out;
        end else begin
            diff_cnt <= diff_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/key_repeat.sv
// Turns two bouncy pushbuttons into mutually exclusive active-low INC/DEC strobes
// with single-step on press, auto-repeat on hold and lockout when both are pressed.
module key_repeat
    import key_repeat_pkg::*;
#(
    parameter int DEB_CYCLES    = 50000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int PULSE_CYCLES  = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_UP,
    input  logic BTN_DN,
    output logic INC,
    output logic DEC,
    output logic HELD
);

    localparam int PW = count_width(PULSE_CYCLES);
    localparam int IW = count_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_CYCLES - 1);
    localparam logic [IW-1:0] HOLD_LAST   = IW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] REPEAT_LAST = IW'(REPEAT_CYCLES - 1);

    logic          up_lvl;
    logic          dn_lvl;
    logic          up_prev;
    logic          dn_prev;
    logic          up_p;
    logic          dn_p;
    logic          act_lvl;
    logic          other_p;
    logic          pulse_done;
    logic          interval_done;
    state_t        state;
    state_t        state_nx;
    logic          dir;
    logic          dir_nx;
    logic          lock_pend;
    logic          lock_pend_nx;
    logic          held_nx;
    logic          inc_nx;
    logic          dec_nx;
    logic [PW-1:0] pulse_cnt;
    logic [IW-1:0] interval_cnt;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .CLK   (CLK),
        .RST   (RST),
        .RAW   (BTN_UP),
        .LEVEL (up_lvl)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .CLK   (CLK),
        .RST   (RST),
        .RAW   (BTN_DN),
        .LEVEL (dn_lvl)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            up_prev <= 1'b0;
            dn_prev <= 1'b0;
        end else begin
            up_prev <= up_lvl;
            dn_prev <= dn_lvl;
        end
    end

    assign up_p    = up_lvl & ~up_prev;
    assign dn_p    = dn_lvl & ~dn_prev;
    assign act_lvl = (dir == DIR_UP) ? up_lvl : dn_lvl;
    assign other_p = (dir == DIR_UP) ? dn_p : up_p;

    // HELD doubles as the first-pulse marker: low for the hold wait, high for repeats.
    assign pulse_done    = (pulse_cnt == PULSE_LAST);
    assign interval_done = HELD ? (interval_cnt == REPEAT_LAST) : (interval_cnt == HOLD_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            dir          <= DIR_UP;
            lock_pend    <= 1'b0;
            pulse_cnt    <= '0;
            interval_cnt <= '0;
            INC          <= 1'b1;
            DEC          <= 1'b1;
            HELD         <= 1'b0;
        end else begin
            state     <= state_nx;
            dir       <= dir_nx;
            lock_pend <= lock_pend_nx;
            INC       <= inc_nx;
            DEC       <= dec_nx;
            HELD      <= held_nx;
            pulse_cnt <= (state == ST_PULSE && state_nx == ST_PULSE) ? pulse_cnt + PW'(1) : '0;
            if (state_nx == ST_PULSE && state != ST_PULSE) begin
                interval_cnt <= '0;
            end else if (state == ST_IDLE || state == ST_LOCK) begin
                interval_cnt <= '0;
            end else begin
                interval_cnt <= interval_cnt + IW'(1);
            end
        end
    end

    // A pulse is never cut short: release or a second button only act once it completes.
    always_comb begin
        state_nx     = state;
        dir_nx       = dir;
        lock_pend_nx = lock_pend;
        case (state)
            ST_IDLE: begin
                lock_pend_nx = 1'b0;
                if (up_p && dn_p) begin
                    state_nx = ST_LOCK;
                end else if (up_p) begin
                    dir_nx   = DIR_UP;
                    state_nx = ST_PULSE;
                end else if (dn_p) begin
                    dir_nx   = DIR_DN;
                    state_nx = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (other_p) lock_pend_nx = 1'b1;
                if (pulse_done) begin
                    if (lock_pend || other_p) state_nx = ST_LOCK;
                    else if (!act_lvl)        state_nx = ST_IDLE;
                    else if (HELD)            state_nx = ST_REPEAT;
                    else                      state_nx = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!act_lvl)          state_nx = ST_IDLE;
                else if (other_p)      state_nx = ST_LOCK;
                else if (interval_done) state_nx = ST_PULSE;
            end
            ST_LOCK: begin
                lock_pend_nx = 1'b0;
                if (!up_lvl && !dn_lvl) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        held_nx = 1'b0;
        if (state_nx == ST_PULSE)  held_nx = HELD | (state == ST_HOLD);
        if (state_nx == ST_REPEAT) held_nx = HELD;
        inc_nx = !(state_nx == ST_PULSE && dir_nx == DIR_UP);
        dec_nx = !(state_nx == ST_PULSE && dir_nx == DIR_DN);
    end

endmodule

// File: tb/tb_key_repeat.sv
// Self-checking bench for key_repeat: vector table, hand-written corner sequences
// and random button activity compared cycle by cycle against a timestamp-based model.
module tb_key_repeat;

    localparam int DEB  = 4;
    localparam int HOLD = 40;
    localparam int REP  = 10;
    localparam int PUL  = 2;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic inc;
    logic dec;
    logic held;

    key_repeat #(
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .PULSE_CYCLES  (PUL)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .BTN_UP (btn_up),
        .BTN_DN (btn_dn),
        .INC    (inc),
        .DEC    (dec),
        .HELD   (held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    int inc_falls[$];
    int inc_rises[$];
    int dec_falls[$];
    int held_rises[$];
    int held_falls[$];

    typedef enum int {M_IDLE, M_ACTIVE, M_LOCK} mode_t;
    mode_t m_mode;
    bit    m_dir;
    int    m_n;
    int    m_pstart;
    int    m_pend;
    int    m_next;
    bit    m_lock_after;
    bit    m_held;
    bit    m_lvl[2];
    bit    m_seen[2];
    bit    m_prev[2];
    int    m_agree[2];
    bit    hist[2][$];
    bit    exp_inc;
    bit    exp_dec;
    bit    exp_held;

    typedef struct {
        bit up;
        bit dn;
        int len;
        int exp_inc;
        int exp_dec;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        inc_falls.delete();
        inc_rises.delete();
        dec_falls.delete();
        held_rises.delete();
        held_falls.delete();
    endtask

    task automatic apply_stimulus(input bit up, input bit dn, input int len);
        btn_up = up;
        btn_dn = dn;
        tick(len);
        btn_up = 1'b0;
        btn_dn = 1'b0;
    endtask

    function automatic int at_or_neg(input int q[$], input int idx, input int base);
        return (q.size() > idx) ? q[idx] - base : -1;
    endfunction

    // Reference model: debounced levels from a "last agreeing sample" timestamp,
    // then the press/hold/repeat behaviour as a schedule of pulse start times.
    task automatic model_reset();
        m_mode       = M_IDLE;
        m_dir        = 1'b0;
        m_n          = 0;
        m_pstart     = 0;
        m_pend       = 0;
        m_next       = 0;
        m_lock_after = 1'b0;
        m_held       = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b]   = 1'b0;
            m_seen[b]  = 1'b0;
            m_prev[b]  = 1'b0;
            m_agree[b] = 0;
            hist[b].delete();
            hist[b].push_back(1'b0);
            hist[b].push_back(1'b0);
        end
        exp_inc  = 1'b1;
        exp_dec  = 1'b1;
        exp_held = 1'b0;
    endtask

    task automatic start_pulse(input bit first);
        m_pstart     = m_n;
        m_pend       = m_n + PUL;
        m_next       = m_n + (first ? HOLD : REP);
        m_lock_after = 1'b0;
        if (!first) m_held = 1'b1;
    endtask

    task automatic model_step();
        bit up_p, dn_p, act_seen, other_p, v, low;
        m_n++;
        up_p     = m_seen[0] && !m_prev[0];
        dn_p     = m_seen[1] && !m_prev[1];
        act_seen = m_seen[m_dir];
        other_p  = m_dir ? up_p : dn_p;
        case (m_mode)
            M_IDLE: begin
                if (up_p && dn_p) begin
                    m_mode = M_LOCK;
                end else if (up_p || dn_p) begin
                    m_mode = M_ACTIVE;
                    m_dir  = dn_p;
                    start_pulse(1'b1);
                end
            end
            M_LOCK: begin
                if (!m_seen[0] && !m_seen[1]) m_mode = M_IDLE;
            end
            default: begin
                if (m_n <= m_pend) begin
                    if (other_p) m_lock_after = 1'b1;
                    if (m_n == m_pend && m_lock_after) begin
                        m_mode = M_LOCK;
                        m_held = 1'b0;
                    end else if (m_n == m_pend && !act_seen) begin
                        m_mode = M_IDLE;
                        m_held = 1'b0;
                    end
                end else if (!act_seen) begin
                    m_mode = M_IDLE;
                    m_held = 1'b0;
                end else if (other_p) begin
                    m_mode = M_LOCK;
                    m_held = 1'b0;
                end else if (m_n == m_next) begin
                    start_pulse(1'b0);
                end
            end
        endcase
        low      = (m_mode == M_ACTIVE) && (m_n >= m_pstart) && (m_n < m_pend);
        exp_inc  = !(low && m_dir == 1'b0);
        exp_dec  = !(low && m_dir == 1'b1);
        exp_held = m_held;

        hist[0].push_back(btn_up);
        hist[1].push_back(btn_dn);
        for (int b = 0; b < 2; b++) begin
            v = hist[b].pop_front();
            if (v == m_lvl[b]) begin
                m_agree[b] = m_n;
            end else if (m_n - m_agree[b] >= DEB) begin
                m_lvl[b]   = v;
                m_agree[b] = m_n;
            end
        end
        m_prev = m_seen;
        m_seen = m_lvl;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic inc_q, dec_q, held_q;
        inc_q  = 1'b1;
        dec_q  = 1'b1;
        held_q = 1'b0;
        forever begin
            @(negedge clk);
            if (inc_q && !inc)   inc_falls.push_back(cyc);
            if (!inc_q && inc)   inc_rises.push_back(cyc);
            if (dec_q && !dec)   dec_falls.push_back(cyc);
            if (!held_q && held) held_rises.push_back(cyc);
            if (held_q && !held) held_falls.push_back(cyc);
            inc_q  = inc;
            dec_q  = dec;
            held_q = held;
            if (chk_en && !rst) begin
                checks++;
                if (inc !== exp_inc || dec !== exp_dec || held !== exp_held) begin
                    errors++;
                    $display("[TB] FAIL model cyc=%0d: got inc/dec/held=%b%b%b, want %b%b%b",
                             cyc, inc, dec, held, exp_inc, exp_dec, exp_held);
                end
            end
        end
    end

    initial begin
        int pc;
        int waited;
        bit burst[12];

        vecs[0] = '{1'b1, 1'b0, 20, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 20, 0, 1};
        vecs[2] = '{1'b1, 1'b0,  3, 0, 0};
        vecs[3] = '{1'b0, 1'b1,  2, 0, 0};
        vecs[4] = '{1'b1, 1'b0,  4, 1, 0};
        vecs[5] = '{1'b1, 1'b1, 20, 0, 0};
        vecs[6] = '{1'b1, 1'b0, 95, 7, 0};
        vecs[7] = '{1'b0, 1'b1, 45, 0, 2};
        burst   = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0};

        tick(3);
        check_output("reset_inc", inc, 1);
        check_output("reset_dec", dec, 1);
        check_output("reset_held", held, 0);
        #2 rst = 1'b0;
        tick(2);
        chk_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            clear_mon();
            apply_stimulus(vecs[i].up, vecs[i].dn, vecs[i].len);
            tick(70);
            check_output($sformatf("vec%0d_inc_pulses", i), inc_falls.size(), vecs[i].exp_inc);
            check_output($sformatf("vec%0d_dec_pulses", i), dec_falls.size(), vecs[i].exp_dec);
            check_output($sformatf("vec%0d_held_idle", i), held, 0);
        end

        // Clean tap: latency and width of the single pulse.
        clear_mon();
        pc = cyc;
        apply_stimulus(1'b1, 1'b0, 20);
        tick(30);
        check_output("tap_latency", at_or_neg(inc_falls, 0, pc), 2 + DEB + 1);
        check_output("tap_width", at_or_neg(inc_rises, 0, pc) - at_or_neg(inc_falls, 0, pc), PUL);
        check_output("tap_count", inc_falls.size(), 1);
        check_output("tap_no_dec", dec_falls.size(), 0);
        check_output("tap_no_held", held_rises.size(), 0);

        // Bounce bursts alone produce nothing; bursts then a steady press give one pulse.
        clear_mon();
        for (int k = 0; k < 12; k++) begin
            btn_dn = burst[k];
            tick(1);
        end
        btn_dn = 1'b0;
        tick(20);
        check_output("bounce_only_dec", dec_falls.size(), 0);
        for (int k = 0; k < 12; k++) begin
            btn_dn = burst[k];
            tick(1);
        end
        apply_stimulus(1'b0, 1'b1, 20);
        tick(40);
        check_output("bounce_press_dec", dec_falls.size(), 1);
        check_output("bounce_press_inc", inc_falls.size(), 0);

        // Long hold: repeat schedule and HELD timing.
        clear_mon();
        pc = cyc;
        apply_stimulus(1'b1, 1'b0, 100);
        tick(40);
        check_output("hold_count", inc_falls.size(), 7);
        check_output("hold_first_latency", at_or_neg(inc_falls, 0, pc), 2 + DEB + 1);
        for (int i = 1; i < 7; i++) begin
            check_output($sformatf("hold_pulse%0d_offset", i),
                         at_or_neg(inc_falls, i, at_or_neg(inc_falls, 0, 0)), HOLD + (i - 1) * REP);
        end
        check_output("hold_held_rise", at_or_neg(held_rises, 0, at_or_neg(inc_falls, 0, 0)), HOLD);
        check_output("hold_held_end", held, 0);

        // Release seen during the first repeat pulse: pulse completes, then idle.
        clear_mon();
        pc = cyc;
        apply_stimulus(1'b1, 1'b0, 41);
        tick(30);
        check_output("relpulse_count", inc_falls.size(), 2);
        check_output("relpulse_start", at_or_neg(inc_falls, 1, pc), 2 + DEB + 1 + HOLD);
        check_output("relpulse_width", at_or_neg(inc_rises, 1, 0) - at_or_neg(inc_falls, 1, 0), PUL);
        check_output("relpulse_held_drop", at_or_neg(held_falls, 0, 0), at_or_neg(inc_rises, 1, 0));
        check_output("relpulse_held", held, 0);

        // Second button during a repeat pulse: finish it, then lock until both are released.
        clear_mon();
        pc = cyc;
        btn_up = 1'b1;
        tick(61);
        btn_dn = 1'b1;
        tick(60);
        check_output("lock_inc_count", inc_falls.size(), 4);
        check_output("lock_last_rise", at_or_neg(inc_rises, 3, pc), 2 + DEB + 1 + HOLD + 2 * REP + PUL);
        check_output("lock_no_dec", dec_falls.size(), 0);
        check_output("lock_held", held, 0);
        btn_up = 1'b0;
        tick(20);
        check_output("lock_one_released", inc_falls.size() + dec_falls.size(), 4);
        btn_dn = 1'b0;
        tick(20);
        clear_mon();
        apply_stimulus(1'b0, 1'b1, 20);
        tick(40);
        check_output("unlock_dec_tap", dec_falls.size(), 1);
        check_output("unlock_inc_none", inc_falls.size(), 0);

        // Reset while a repeat pulse is low.
        btn_up = 1'b1;
        waited = 0;
        while (!held && waited < 100) begin
            tick(1);
            waited++;
        end
        check_output("rst_held_reached", held, 1);
        check_output("rst_inc_low", inc, 0);
        #2;
        rst    = 1'b1;
        btn_up = 1'b0;
        #1;
        check_output("rst_async_inc", inc, 1);
        check_output("rst_async_held", held, 0);
        tick(2);
        #2 rst = 1'b0;
        clear_mon();
        tick(50);
        check_output("rst_no_pulses", inc_falls.size() + dec_falls.size(), 0);
        apply_stimulus(1'b1, 1'b0, 20);
        tick(40);
        check_output("rst_fresh_tap", inc_falls.size(), 1);

        // Random button activity checked against the model every cycle.
        for (int s = 0; s < 60; s++) begin
            int kind;
            int len;
            bit bouncy;
            bit u;
            bit d;
            kind   = $urandom_range(0, 3);
            len    = $urandom_range(1, 90);
            bouncy = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < len; c++) begin
                u = (kind == 1 || kind == 3);
                d = (kind == 2 || kind == 3);
                if (bouncy && $urandom_range(0, 2) == 0) u = !u;
                if (bouncy && $urandom_range(0, 2) == 0) d = !d;
                btn_up = u;
                btn_dn = d;
                tick(1);
            end
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        tick(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
# key_repeat

Front-end conditioner for the up/down timer digits. Turns two raw pushbuttons (up, down) into clean, mutually exclusive INC/DEC strobes for the cascaded BCD counter chain. Each strobe is an active-low pulse whose rising edge performs the count. The block provides:
- synchronisation of the raw button inputs,
- debouncing,
- single-step on press,
- auto-repeat on hold,
- lockout when both buttons are pressed.

## Interface
Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles required to accept a button level change.
- HOLD_CYCLES, 25000000: cycles from the start of the first pulse until auto-repeat begins.
- REPEAT_CYCLES, 5000000: auto-repeat pulse spacing, start-to-start; must be greater than PULSE_CYCLES + 1.
- PULSE_CYCLES, 4: low time of each INC/DEC pulse; minimum 1.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- BTN_UP  in  1  raw up button, active-high, asynchronous to CLK, bouncy.
- BTN_DN  in  1  raw down button, active-high, asynchronous to CLK, bouncy.
- INC  out  1  increment strobe to the counter, idle high; the rising edge counts.
- DEC  out  1  decrement strobe to the counter, idle high; the rising edge counts.
- HELD  out  1  high while in auto-repeat.

## Operation
- Reset values: INC=1, DEC=1, HELD=0. FSM=IDLE. Debounced levels=0. All counters=0.
- Input path: each button passes through a 2-flop synchroniser, then a debouncer.
- Debouncer rule: the stable level toggles only after DEB_CYCLES consecutive synchronised samples that differ from it. Any agreeing sample restarts the count.
- Press events: the rising edges of the debounced levels, up_p and dn_p.
- FSM states: IDLE, PULSE, HOLD, REPEAT, LOCK. A direction register `dir` selects INC or DEC.
- IDLE transitions:
  - up_p alone: dir=up, go to PULSE.
  - dn_p alone: dir=dn, go to PULSE.
  - up_p and dn_p in the same cycle: go to LOCK.
- PULSE: the selected output is low for exactly PULSE_CYCLES cycles, then returns high. Exit when the pulse completes:
  - to HOLD if the first pulse of this press is finishing;
  - to REPEAT if it is a repeat pulse.
- HOLD: waits until HOLD_CYCLES have elapsed from the start of the first pulse, then asserts HELD and goes to PULSE.
- REPEAT: issues the next PULSE REPEAT_CYCLES after the previous pulse start. HELD stays high.
- Release: when the active button's debounced level falls in HOLD or REPEAT, go to IDLE and set HELD=0.
- Release during PULSE: the pulse is never truncated. It completes, then the FSM goes to IDLE.
- Other button pressed while one is active: finish any in-flight pulse, then go to LOCK. No further pulses.
- LOCK: all outputs idle; leave to IDLE only when both debounced levels are 0.
- Invariant: INC and DEC are never low in the same cycle. At most one output toggles per cycle.
- RST mid-pulse: the low output returns high asynchronously. The integrator ties the counter clear to the same reset, so the resulting edge is harmless.

## Timing
- Press to first INC/DEC falling edge: 2 (synchroniser) + DEB_CYCLES + 1 (edge detect/FSM) cycles.
- Pulse: low for PULSE_CYCLES; the rising edge falls PULSE_CYCLES after the falling edge.
- First repeat falling edge: HOLD_CYCLES after the first pulse falling edge. HELD rises in the same cycle.
- Subsequent repeats: every REPEAT_CYCLES.
- Release to IDLE: 2 + DEB_CYCLES + 1 cycles, extended to the end of any in-flight pulse.
- Outputs are registered with no combinational paths from inputs, so they are glitch-free for edge-sensitive consumers.

## Structure
- Package key_repeat_pkg:
  - FSM state enum;
  - a width helper function, ceiling log2, used to size counters from the parameters;
  - direction constants DIR_UP and DIR_DN.
- One sub-module, key_debounce: synchroniser plus stable-count filter, with ports CLK, RST, RAW, LEVEL. Instantiated twice.
- The top level holds the FSM, the pulse counter and a shared hold/repeat interval counter.

## Test plan
Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=40, REPEAT_CYCLES=10, PULSE_CYCLES=2.
- Clean tap of BTN_UP for 20 cycles: exactly one INC low pulse, 2 cycles wide, starting 7 cycles after the press. DEC stays 1 and HELD stays 0.
- BTN_DN with 3-cycle bounce bursts (1-2 cycle glitches) before settling: exactly one DEC pulse. Glitches shorter than 4 cycles produce none.
- Hold BTN_UP for 100 cycles:
  - first INC pulse at t0;
  - HELD rises at t0+40;
  - further INC pulses at t0+40, +50, +60, and so on until release;
  - total count matches.
- Release BTN_UP mid-pulse: that pulse still lasts 2 full cycles, then FSM is IDLE and HELD=0.
- BTN_UP held in REPEAT, then BTN_DN pressed: no DEC pulse ever. INC stops after the in-flight pulse. Outputs stay idle until both are released, then a new DEC tap works.
- Assert RST while INC is low: INC=1, HELD=0 immediately, without waiting for a clock edge. After deassertion there are no pulses until a fresh press.
